// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation sequencer: FSM states, opcodes and
// the result flag bundle.
package alu_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_LOAD_A = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOAD_B = 2'd1;
  localparam logic [STATE_W-1:0] ST_EXEC   = 2'd2;
  localparam logic [STATE_W-1:0] ST_SHOW   = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic err;
  } flags_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative unsigned multiply (shift-add) and restoring divide datapath.
// One iteration per clock; the first iteration works directly on the inputs.
module alu_iter_unit #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   b_q;
  logic               div_q;
  logic               running;
  logic [CNTW-1:0]    cnt_q;

  logic               first;
  logic               active;
  logic               last;
  logic [2*WIDTH-1:0] cur_p;
  logic [WIDTH-1:0]   cur_b;
  logic               cur_div;
  logic [CNTW-1:0]    idx;
  logic [WIDTH:0]     mul_hi;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_r;
  logic [2*WIDTH-1:0] p_next;

  // p holds {partial_high, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    first   = start & ~running;
    active  = first | running;
    cur_p   = first ? {{WIDTH{1'b0}}, a} : p_q;
    cur_b   = first ? b : b_q;
    cur_div = first ? is_div : div_q;
    idx     = first ? '0 : cnt_q;
    last    = (idx == CNTW'(WIDTH - 1));

    mul_hi  = {1'b0, cur_p[2*WIDTH-1:WIDTH]} + (cur_p[0] ? {1'b0, cur_b} : '0);
    div_sh  = {cur_p[2*WIDTH-1:WIDTH], cur_p[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, cur_b});
    div_r   = div_sh[WIDTH-1:0] - cur_b;

    if (cur_div)
      p_next = {(div_ge ? div_r : div_sh[WIDTH-1:0]), cur_p[WIDTH-2:0], div_ge};
    else
      p_next = {mul_hi, cur_p[WIDTH-1:1]};
  end

  assign busy   = running;
  assign done   = active & last;
  assign result = p_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      running <= 1'b0;
      cnt_q   <= '0;
    end else if (clear) begin
      running <= 1'b0;
      cnt_q   <= '0;
    end else if (active) begin
      p_q   <= p_next;
      b_q   <= cur_b;
      div_q <= cur_div;
      if (last) begin
        running <= 1'b0;
        cnt_q   <= '0;
      end else begin
        running <= 1'b1;
        cnt_q   <= idx + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Step-driven ALU sequencer: loads A and B from the data bus, executes one
// operation (single-cycle or iterative) and holds the result for display.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 clear,
  input  logic                 chain,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [3:0]           op,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic [2*WIDTH-1:0]   y_out,
  output logic                 carry,
  output logic                 zero,
  output logic                 ovf,
  output logic                 err,
  output logic                 busy,
  output logic                 done,
  output logic [STATE_W-1:0]   state_out
);

  logic [STATE_W-1:0] state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] y_q;
  logic [3:0]         op_q;
  flags_t             flags_q;
  logic               step_q;
  logic               done_q;

  logic               step_pulse;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [CNTW-1:0]    shamt;
  logic               div_by_zero;
  logic               iter_op;
  logic               iter_start;
  logic               iter_busy;
  logic               iter_done;
  logic [2*WIDTH-1:0] iter_result;
  logic [2*WIDTH-1:0] sc_y;
  flags_t             sc_flags;

  assign step_pulse  = step & ~step_q;
  assign sum         = {1'b0, a_q} + {1'b0, b_q};
  assign diff        = a_q - b_q;
  assign shamt       = b_q[CNTW-1:0];
  assign div_by_zero = (op_q == OP_DIV) && (b_q == '0);
  assign iter_op     = is_iter_op(op_q) && !div_by_zero;
  assign iter_start  = (state == ST_EXEC) && iter_op && !iter_busy;

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_iter (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .start  (iter_start),
    .is_div (op_q == OP_DIV),
    .a      (a_q),
    .b      (b_q),
    .busy   (iter_busy),
    .done   (iter_done),
    .result (iter_result)
  );

  // Single-cycle result; DIV by zero is resolved here without iterating
  always_comb begin
    sc_y     = '0;
    sc_flags = '0;
    case (op_q)
      OP_ADD: begin
        sc_y[WIDTH-1:0] = sum[WIDTH-1:0];
        sc_flags.carry  = sum[WIDTH];
        sc_flags.ovf    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        sc_y[WIDTH-1:0] = diff;
        sc_flags.carry  = (a_q >= b_q);
        sc_flags.ovf    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: sc_y[WIDTH-1:0] = a_q & b_q;
      OP_OR:  sc_y[WIDTH-1:0] = a_q | b_q;
      OP_XOR: sc_y[WIDTH-1:0] = a_q ^ b_q;
      OP_NOT: sc_y[WIDTH-1:0] = ~a_q;
      OP_SHL: sc_y[WIDTH-1:0] = a_q << shamt;
      OP_SHR: sc_y[WIDTH-1:0] = a_q >> shamt;
      OP_MUL: sc_y = '0;
      OP_DIV: begin
        if (div_by_zero) begin
          sc_y         = '1;
          sc_flags.err = 1'b1;
        end
      end
      OP_CMP: begin
        sc_y[0] = (a_q == b_q);
        sc_y[1] = (a_q < b_q);
        sc_y[2] = ($signed(a_q) < $signed(b_q));
      end
      default: sc_flags.err = 1'b1;
    endcase
    sc_flags.zero = (sc_y == '0);
  end

  // Control FSM; clear wins over step in every state and aborts iteration
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      flags_q <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      step_q <= step;
      done_q <= 1'b0;
      if (clear) begin
        state   <= ST_LOAD_A;
        a_q     <= '0;
        b_q     <= '0;
        y_q     <= '0;
        op_q    <= '0;
        flags_q <= '0;
      end else begin
        case (state)
          ST_LOAD_A: begin
            if (step_pulse) begin
              a_q   <= data_in;
              state <= ST_LOAD_B;
            end
          end
          ST_LOAD_B: begin
            if (step_pulse) begin
              b_q   <= data_in;
              op_q  <= op;
              state <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            if (!iter_op) begin
              y_q     <= sc_y;
              flags_q <= sc_flags;
              done_q  <= 1'b1;
              state   <= ST_SHOW;
            end else if (iter_done) begin
              y_q           <= iter_result;
              flags_q       <= '0;
              flags_q.zero  <= (iter_result == '0);
              done_q        <= 1'b1;
              state         <= ST_SHOW;
            end
          end
          ST_SHOW: begin
            if (step_pulse) begin
              if (chain) begin
                a_q   <= y_q[WIDTH-1:0];
                state <= ST_LOAD_B;
              end else begin
                state <= ST_LOAD_A;
              end
            end
          end
          default: state <= ST_LOAD_A;
        endcase
      end
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign y_out     = y_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign ovf       = flags_q.ovf;
  assign err       = flags_q.err;
  assign busy      = (state == ST_EXEC);
  assign done      = done_q;
  assign state_out = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer at WIDTH=8 with hand-computed results.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               step = 1'b0;
  logic               clear = 1'b0;
  logic               chain = 1'b0;
  logic [WIDTH-1:0]   data_in = '0;
  logic [3:0]         op = '0;
  logic [WIDTH-1:0]   a_out;
  logic [WIDTH-1:0]   b_out;
  logic [2*WIDTH-1:0] y_out;
  logic               carry;
  logic               zero;
  logic               ovf;
  logic               err;
  logic               busy;
  logic               done;
  logic [1:0]         state_out;

  int checks = 0;
  int failures = 0;
  int bc;
  int ds;

  always #5 clock = ~clock;

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .step      (step),
    .clear     (clear),
    .chain     (chain),
    .data_in   (data_in),
    .op        (op),
    .a_out     (a_out),
    .b_out     (b_out),
    .y_out     (y_out),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf),
    .err       (err),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value, input logic [3:0] op_sel, input logic chain_sel);
    @(negedge clock);
    data_in = value;
    op      = op_sel;
    chain   = chain_sel;
    step    = 1'b1;
    @(negedge clock);
    step    = 1'b0;
  endtask

  // Counts EXEC cycles; optionally wiggles step to create ignored edges
  task automatic runExec(input logic poke, output int busy_cycles, output int done_seen);
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      if (poke) step = (busy_cycles == 2 || busy_cycles == 3 || busy_cycles == 5);
      @(negedge clock);
    end
    step = 1'b0;
    done_seen = int'(done);
  endtask

  task automatic doOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [3:0] opc,
                      input logic poke, input int exp_busy, input logic [15:0] exp_y, input logic [3:0] exp_flags);
    int busy_cycles;
    int done_seen;
    applyStimulus(a, 4'h0, 1'b0);
    applyStimulus(b, opc, 1'b0);
    runExec(poke, busy_cycles, done_seen);
    checkOutput({tag, " busy_cycles"}, busy_cycles, exp_busy);
    checkOutput({tag, " done"}, done_seen, 1);
    checkOutput({tag, " y"}, y_out, exp_y);
    checkOutput({tag, " flags"}, {carry, zero, ovf, err}, exp_flags);
    @(negedge clock);
    checkOutput({tag, " done_low"}, done, 0);
    checkOutput({tag, " state_show"}, state_out, ST_SHOW);
  endtask

  initial begin
    #2 reset = 1'b0;
    #3;
    checkOutput("reset state", state_out, ST_LOAD_A);
    checkOutput("reset a_b", {a_out, b_out}, 0);
    checkOutput("reset y", y_out, 0);
    checkOutput("reset ctl_flags", {carry, zero, ovf, err, busy, done}, 0);
    @(negedge clock);
    reset = 1'b1;

    doOp("add", 8'hF0, 8'h20, OP_ADD, 1'b0, 1, 16'h0010, 4'b1000);
    applyStimulus(8'h00, 4'h0, 1'b0);
    checkOutput("add back_to_load_a", state_out, ST_LOAD_A);
    checkOutput("add y_hold", y_out, 16'h0010);

    doOp("sub_ovf", 8'h80, 8'h01, OP_SUB, 1'b0, 1, 16'h007F, 4'b1010);
    applyStimulus(8'h00, 4'h0, 1'b0);
    doOp("sub_zero", 8'h05, 8'h05, OP_SUB, 1'b0, 1, 16'h0000, 4'b1100);
    applyStimulus(8'h00, 4'h0, 1'b0);

    doOp("mul_ff", 8'hFF, 8'hFF, OP_MUL, 1'b1, 8, 16'hFE01, 4'b0000);
    @(negedge clock);
    checkOutput("mul still_show", state_out, ST_SHOW);
    applyStimulus(8'h00, 4'h0, 1'b0);

    doOp("div", 8'h64, 8'h07, OP_DIV, 1'b0, 8, 16'h020E, 4'b0000);
    applyStimulus(8'h00, 4'h0, 1'b0);
    doOp("div0", 8'h37, 8'h00, OP_DIV, 1'b0, 1, 16'hFFFF, 4'b0001);
    applyStimulus(8'h00, 4'h0, 1'b0);

    doOp("cmp", 8'h80, 8'h01, OP_CMP, 1'b0, 1, 16'h0004, 4'b0000);
    applyStimulus(8'h00, 4'h0, 1'b0);
    doOp("undef", 8'h12, 8'h34, 4'd12, 1'b0, 1, 16'h0000, 4'b0101);
    applyStimulus(8'h00, 4'h0, 1'b0);
    doOp("shr_big", 8'hF0, 8'h09, OP_SHR, 1'b0, 1, 16'h0000, 4'b0100);
    applyStimulus(8'h00, 4'h0, 1'b0);
    doOp("shl", 8'h0F, 8'h04, OP_SHL, 1'b0, 1, 16'h00F0, 4'b0000);
    applyStimulus(8'h00, 4'h0, 1'b0);
    doOp("not", 8'h0F, 8'h00, OP_NOT, 1'b0, 1, 16'h00F0, 4'b0000);
    applyStimulus(8'h00, 4'h0, 1'b0);

    doOp("chain_add", 8'h10, 8'h05, OP_ADD, 1'b0, 1, 16'h0015, 4'b0000);
    applyStimulus(8'h00, 4'h0, 1'b1);
    checkOutput("chain a", a_out, 8'h15);
    checkOutput("chain state", state_out, ST_LOAD_B);
    applyStimulus(8'h03, OP_MUL, 1'b0);
    runExec(1'b0, bc, ds);
    checkOutput("chain_mul busy_cycles", bc, 8);
    checkOutput("chain_mul y", y_out, 16'h003F);
    applyStimulus(8'h00, 4'h0, 1'b0);

    applyStimulus(8'hFF, 4'h0, 1'b0);
    applyStimulus(8'hFF, OP_MUL, 1'b0);
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_abort state", state_out, ST_LOAD_A);
    checkOutput("rst_abort a_b", {a_out, b_out}, 0);
    checkOutput("rst_abort y", y_out, 0);
    checkOutput("rst_abort ctl_flags", {carry, zero, ovf, err, busy, done}, 0);
    @(negedge clock);
    reset = 1'b1;

    doOp("and", 8'hCC, 8'hAA, OP_AND, 1'b0, 1, 16'h0088, 4'b0000);
    applyStimulus(8'h00, 4'h0, 1'b0);

    applyStimulus(8'h12, 4'h0, 1'b0);
    applyStimulus(8'h34, OP_MUL, 1'b0);
    repeat (3) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    checkOutput("clr_abort state", state_out, ST_LOAD_A);
    checkOutput("clr_abort a_b", {a_out, b_out}, 0);
    checkOutput("clr_abort y", y_out, 0);
    checkOutput("clr_abort ctl_flags", {carry, zero, ovf, err, busy, done}, 0);
    clear = 1'b0;

    doOp("mul_after_clear", 8'h03, 8'h05, OP_MUL, 1'b0, 8, 16'h000F, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Parametrised, multi-cycle successor to the board-level ALU operation mux.
- Captures operands A and B from a WIDTH-bit data bus under a step/clear control FSM.
- Executes single-cycle and iterative (multiply, divide) operations and holds a 2*WIDTH result with status flags for the LED/7-segment display path.
- Supports chaining: the previous result becomes the next A.

Parameters:
- WIDTH, 8, operand width in bits (4..16).
- CNTW, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- step  input  1  level from debounced button, synchronous to clock; internally edge-detected.
- clear  input  1  synchronous clear of A/B/Y/flags; FSM returns to LOAD_A.
- chain  input  1  sampled on step in SHOW: 1 = reuse Y as next A.
- data_in  input  WIDTH  operand data.
- op  input  4  operation select, sampled on the step that leaves LOAD_B.
- a_out  output  WIDTH  current A register.
- b_out  output  WIDTH  current B register.
- y_out  output  2*WIDTH  result register.
- carry  output  1  ADD carry-out, or SUB no-borrow (A>=B).
- zero  output  1  y_out == 0.
- ovf  output  1  signed overflow, ADD/SUB only.
- err  output  1  divide-by-zero or undefined op.
- busy  output  1  high while in EXEC.
- done  output  1  one-cycle pulse on the EXEC->SHOW transition.
- state_out  output  2  FSM state encoding.

Behaviour:
- Reset (reset=0, async): all outputs 0, state LOAD_A, step history register 0.
- step_pulse = step & ~step_q, where step_q is step registered. Exactly one action per rising edge of step.
- States: LOAD_A=0, LOAD_B=1, EXEC=2, SHOW=3.
  - LOAD_A: on step_pulse, A<=data_in; go to LOAD_B.
  - LOAD_B: on step_pulse, B<=data_in, op latched into op_q; go to EXEC.
  - EXEC, single-cycle ops: Y and flags written on the first EXEC cycle; next cycle SHOW with done=1. busy is high for 1 cycle.
  - EXEC, MUL/DIV: WIDTH iteration cycles, then SHOW. busy is high for exactly WIDTH cycles; done pulses on the cycle the state becomes SHOW.
  - SHOW: on step_pulse with chain=0, go to LOAD_A (A/B/Y hold until overwritten). With chain=1, A<=y_out[WIDTH-1:0] and go to LOAD_B.
  - step_pulse during EXEC is ignored and not queued.
- clear has priority over step_pulse in every state, including mid-EXEC. It aborts the iteration, zeroes A/B/Y/flags and sets state LOAD_A.
- Ops (op_q); results are zero-extended into y_out unless stated:
  - 0 ADD: Y=A+B, carry in bit WIDTH.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT A.
  - 6 SHL: A<<B[CNTW-1:0].
  - 7 SHR (logical): A>>B[CNTW-1:0]; shift >= WIDTH gives 0.
  - 8 MUL: unsigned shift-add, full 2*WIDTH product.
  - 9 DIV: unsigned restoring; Y = {remainder, quotient}.
  - 10 CMP: Y[0]=(A==B), Y[1]=(A<B) unsigned, Y[2]=(A<B) signed.
  - 11-15: Y=0, err=1.
- DIV with B=0: no iteration, single-cycle; Y=all ones, err=1.
- Flags are written only when the result is written. zero is computed on the final Y.
- Flags and Y hold stable throughout SHOW and the following LOAD states.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings (OP_ADD..OP_CMP);
  - state encodings (ST_LOAD_A..ST_SHOW);
  - state_out width constant.
- One natural sub-module, alu_iter_unit: iterative MUL/DIV datapath with start/busy/done handshake and a CNTW counter. The FSM, single-cycle ops and flags stay in the top of the block.

Test Plan (WIDTH=8):
- ADD: A=0xF0, B=0x20, op=0 -> y_out=0x0010, carry=1, zero=0, ovf=0; done 1 cycle after leaving LOAD_B, busy high 1 cycle.
- SUB: A=0x80, B=0x01, op=1 -> y_out=0x007F, ovf=1, carry=1. Also A=0x05, B=0x05 -> zero=1.
- MUL: A=0xFF, B=0xFF, op=8 -> busy high exactly 8 cycles, then y_out=0xFE01 with a single done pulse. Extra step edges during EXEC are ignored.
- DIV: A=0x64, B=0x07, op=9 -> y_out=0x020E. A=0x37, B=0x00 -> y_out=0xFFFF, err=1, busy high 1 cycle.
- Chain: ADD 0x10+0x05 = 0x0015, then step with chain=1 -> a_out=0x15, state LOAD_B. Load B=0x03 with op=8 -> y_out=0x003F.
- Abort: pull reset low at iteration 4 of MUL -> all outputs 0 and state_out=0 asynchronously. Repeat with clear=1 -> same result on the next edge.
